// File: rtl/alu_arbiter_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_seq
// Brief    : Round-robin arbiter sequencing two requesters onto one external
//            4-bit adder with operand mux; settles, samples and returns flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_seq #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [1:0] req0_op,
    input  logic [1:0] req1_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic [1:0] rsp_valid,
    output logic [3:0] rsp_sum,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_ovf,
    output logic [3:0] alu_x,
    output logic [3:0] alu_y,
    output logic       alu_s1,
    output logic       alu_s0,
    output logic       alu_cin,
    input  logic [3:0] alu_sum,
    input  logic       alu_cout
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_DRIVE   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       prio_q, prio_d;
    logic       gnt_q, gnt_d;
    logic [1:0] op_q, op_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [1:0] rsp_valid_q, rsp_valid_d;
    logic [3:0] rsp_sum_q, rsp_sum_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_ovf_q, rsp_ovf_d;
    logic [3:0] alu_x_q, alu_x_d;
    logic [3:0] alu_y_q, alu_y_d;
    logic       alu_s1_q, alu_s1_d;
    logic       alu_s0_q, alu_s0_d;
    logic       alu_cin_q, alu_cin_d;

    logic       w_pick;
    logic       w_accept;
    logic [3:0] w_y_eff;

    // Contention goes to the pointer; a lone requester wins regardless.
    always_comb begin
        w_pick = prio_q;
        if (req_valid == 2'b10) begin
            w_pick = 1'b1;
        end else if (req_valid == 2'b01) begin
            w_pick = 1'b0;
        end
    end

    assign req_ready = (state_q == c_IDLE) ? (w_pick ? 2'b10 : 2'b01) : 2'b00;
    assign w_accept  = |(req_valid & req_ready);

    always_comb begin
        w_y_eff = b_q;
        case (op_q)
            2'b00:   w_y_eff = b_q;
            2'b01:   w_y_eff = ~b_q;
            2'b10:   w_y_eff = 4'h0;
            default: w_y_eff = 4'hF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = 2'b00;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_ovf_d   = rsp_ovf_q;

        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    state_d = c_DRIVE;
                    gnt_d   = w_pick;
                    prio_d  = ~w_pick;
                    op_d    = w_pick ? req1_op : req0_op;
                    a_d     = w_pick ? req1_a  : req0_a;
                    b_d     = w_pick ? req1_b  : req0_b;
                    cnt_d   = c_SETTLE_LOAD;
                end
            end
            c_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d     = c_CAPTURE;
                    rsp_sum_d   = alu_sum;
                    rsp_carry_d = alu_cout;
                    rsp_zero_d  = (alu_sum == 4'h0);
                    rsp_ovf_d   = (a_q[3] == w_y_eff[3]) && (alu_sum[3] != a_q[3]);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            c_CAPTURE: begin
                state_d     = c_IDLE;
                rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Adder controls are registered off the next state so they track DRIVE exactly.
    always_comb begin
        alu_x_d   = 4'h0;
        alu_y_d   = 4'h0;
        alu_s1_d  = 1'b0;
        alu_s0_d  = 1'b0;
        alu_cin_d = 1'b0;
        if (state_d == c_DRIVE) begin
            alu_x_d   = a_d;
            alu_y_d   = b_d;
            alu_s1_d  = op_d[1];
            alu_s0_d  = op_d[0];
            alu_cin_d = op_d[1] ^ op_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            cnt_q       <= 4'd0;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            op_q        <= 2'b00;
            a_q         <= 4'h0;
            b_q         <= 4'h0;
            rsp_valid_q <= 2'b00;
            rsp_sum_q   <= 4'h0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            alu_x_q     <= 4'h0;
            alu_y_q     <= 4'h0;
            alu_s1_q    <= 1'b0;
            alu_s0_q    <= 1'b0;
            alu_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ovf_q   <= rsp_ovf_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_s1_q    <= alu_s1_d;
            alu_s0_q    <= alu_s0_d;
            alu_cin_q   <= alu_cin_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign alu_s1    = alu_s1_q;
    assign alu_s0    = alu_s0_q;
    assign alu_cin   = alu_cin_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter_seq
// Brief    : Scoreboard bench for alu_arbiter_seq with a behavioural shared ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter_seq;

    localparam int SETTLE = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] rsp_valid;
    logic [3:0] rsp_sum;
    logic       rsp_carry, rsp_zero, rsp_ovf;
    logic [3:0] alu_x, alu_y;
    logic       alu_s1, alu_s0, alu_cin;
    logic [3:0] alu_sum;
    logic       alu_cout;

    typedef struct {
        logic       req;
        logic [3:0] sum;
        logic       carry;
        logic       zero;
        logic       ovf;
        int         cyc;
    } exp_t;

    typedef struct {
        logic req;
        int   cyc;
    } acc_t;

    exp_t sb[$];
    acc_t acc_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;
    int dw_start = 0;
    int dw_end   = -1;
    logic [1:0] dw_op;
    logic [3:0] dw_a, dw_b;

    alu_arbiter_seq #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_op   (req0_op),
        .req1_op   (req1_op),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_s1    (alu_s1),
        .alu_s0    (alu_s0),
        .alu_cin   (alu_cin),
        .alu_sum   (alu_sum),
        .alu_cout  (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    // External shared adder: operand mux on y, then x + y_eff + cin.
    logic [3:0] y_mux;
    always_comb begin
        y_mux = alu_y;
        case ({alu_s1, alu_s0})
            2'b00:   y_mux = alu_y;
            2'b01:   y_mux = ~alu_y;
            2'b10:   y_mux = 4'h0;
            default: y_mux = 4'hF;
        endcase
        {alu_cout, alu_sum} = {1'b0, alu_x} + {1'b0, y_mux} + {4'b0, alu_cin};
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic r, input logic [1:0] op,
                                   input logic [3:0] a, input logic [3:0] b);
        exp_t m;
        int ua, ub, sa, sbv, s, res;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua > 7) ? ua - 16 : ua;
        sbv = (ub > 7) ? ub - 16 : ub;
        m.req = r;
        m.cyc = 0;
        case (op)
            2'd0:    begin s = ua + ub;      m.carry = (s > 15);   res = sa + sbv; end
            2'd1:    begin s = ua - ub + 16; m.carry = (ua >= ub); res = sa - sbv; end
            2'd2:    begin s = ua + 1;       m.carry = (ua == 15); res = sa + 1;   end
            default: begin s = ua + 15;      m.carry = (ua != 0);  res = sa - 1;   end
        endcase
        m.sum  = 4'(s % 16);
        m.zero = (m.sum == 4'h0);
        m.ovf  = (res > 7) || (res < -8);
        return m;
    endfunction

    function automatic logic exp_cin(input logic [1:0] op);
        return (op == 2'd1) || (op == 2'd2);
    endfunction

    // Monitor: retires responses, checks the adder drive window, logs accepts.
    always @(negedge clk) begin
        exp_t e;
        logic pk;
        if (!rst_n) begin
            sb.delete();
            dw_start = 0;
            dw_end   = -1;
        end else begin
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_who",   32'(rsp_valid), e.req ? 32'd2 : 32'd1);
                    check("rsp_sum",   32'(rsp_sum),   32'(e.sum));
                    check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                    check("rsp_zero",  32'(rsp_zero),  32'(e.zero));
                    check("rsp_ovf",   32'(rsp_ovf),   32'(e.ovf));
                    check("rsp_lat",   32'(ecount),    32'(e.cyc));
                end
            end
            if (ecount >= dw_start && ecount <= dw_end)
                check("alu_drive", 32'({alu_x, alu_y, alu_s1, alu_s0, alu_cin}),
                      32'({dw_a, dw_b, dw_op, exp_cin(dw_op)}));
            else
                check("alu_quiet", 32'({alu_x, alu_y, alu_s1, alu_s0, alu_cin}), 32'd0);
            if ((req_valid & req_ready) != 2'b00) begin
                pk    = req_ready[1];
                dw_op = pk ? req1_op : req0_op;
                dw_a  = pk ? req1_a  : req0_a;
                dw_b  = pk ? req1_b  : req0_b;
                e     = model(pk, dw_op, dw_a, dw_b);
                e.cyc = ecount + SETTLE + 2;
                sb.push_back(e);
                acc_log.push_back('{req: pk, cyc: ecount});
                dw_start = ecount + 1;
                dw_end   = ecount + SETTLE;
            end
        end
    end

    task automatic issue(input logic r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        @(posedge clk); #1;
        if (r) begin
            req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_op = op; req0_a = a; req0_b = b;
        end
        req_valid[r] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
        check("ready", 32'(req_ready), r ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        check("drain", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req0_op = 2'b00; req1_op = 2'b00;
        req0_a = 4'h0; req0_b = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vals", 32'({rsp_valid, rsp_sum, rsp_carry, rsp_zero, rsp_ovf,
                                 alu_x, alu_y, alu_s1, alu_s0, alu_cin}), 32'd0);
        rst_n = 1'b1;

        issue(1'b0, 2'd0, 4'b0011, 4'b0100); drain();   // ADD 3+4
        issue(1'b1, 2'd1, 4'b0101, 4'b0101); drain();   // SUB 5-5
        issue(1'b0, 2'd2, 4'b0111, 4'b0000); drain();   // INC 7
        issue(1'b0, 2'd3, 4'b1000, 4'b0000); drain();   // DEC 8
        issue(1'b1, 2'd0, 4'b1111, 4'b0001); drain();   // ADD wrap
        for (int i = 0; i < 6; i++) begin
            issue(1'(i % 2), 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
            drain();
        end

        // Both requesters hammering from a fresh reset.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_log.delete();
        req0_op = 2'd0; req0_a = 4'h1; req0_b = 4'h2;
        req1_op = 2'd1; req1_a = 4'h9; req1_b = 4'h3;
        req_valid = 2'b11;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (acc_log.size() >= 8) break;
        end
        req_valid = 2'b00;
        check("grant_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < acc_log.size(); i++) begin
            check("grant_seq", 32'(acc_log[i].req), 32'(i % 2));
            if (i > 0) check("grant_gap", 32'(acc_log[i].cyc - acc_log[i-1].cyc), 32'(SETTLE + 2));
        end
        drain();

        // Abort in the first DRIVE cycle; priority must return to requester 0.
        issue(1'b0, 2'd0, 4'h2, 4'h3);
        rst_n = 1'b0;
        #1;
        check("reset_async", 32'({rsp_valid, rsp_sum, rsp_carry, rsp_zero, rsp_ovf,
                                  alu_x, alu_y, alu_s1, alu_s0, alu_cin}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_op = 2'd2; req0_a = 4'hF; req0_b = 4'h0;
        req1_op = 2'd3; req1_a = 4'h4; req1_b = 4'h0;
        req_valid = 2'b11;
        @(negedge clk);
        check("prio_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
